// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, FSM state encodings and width helpers for dmem_bytelane.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dmem_pkg;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // Word-index width; a single-word memory still needs one index bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Byte-offset width inside one word.
    function automatic int off_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W RAM with per-byte write enables, one write port, one synchronous read port.
// Latency: write lands at the clock edge; read data appears the cycle after re_i.
// Backpressure: none; output register holds until the next re_i, read-first on same-address collision.
//
// Ports: clk_i; write port we_i/wstrb_i/waddr_i/wdata_i; read port re_i/raddr_i/rdata_o.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Both ports in one process: the read samples the pre-edge contents, giving read-first.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed data memory with byte-lane strobes, independent write/response/read handshakes.
// Latency: write committed at accept edge, BVALID next cycle; RVALID/RDATA/RRESP one cycle after read accept.
// Backpressure: one write and one read in flight; AWREADY/ARREADY low until BREADY/RREADY retire the response.
//
// Ports: CLK, RST (async active-high); write request AWVALID/AWREADY/AWADDR/WDATA/WSTRB;
//        write response BVALID/BREADY/BRESP; read request ARVALID/ARREADY/ARADDR;
//        read response RVALID/RREADY/RDATA/RRESP.
// Optional macro DMEM_FWD_EN: a same-cycle legal write and read to one word returns the merged
// (write-first) data instead of the pre-write (read-first) data.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  BRESP,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_W-1:0]     ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_W-1:0]     RDATA,
    output logic                  RRESP
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(DEPTH);
    localparam int OFF_W  = off_width(DATA_W);
    localparam logic [ADDR_W-1:0] OFF_MASK = (ADDR_W'(1) << OFF_W) - ADDR_W'(1);

    // Misaligned if any byte-offset bit is set; out of range if anything above the word index is set.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return ((a & OFF_MASK) != '0) || ((a >> (OFF_W + IDX_W)) != '0);
    endfunction

    wstate_e            w_state_q, w_state_d;
    rstate_e            r_state_q, r_state_d;
    logic               bresp_q, bresp_d;
    logic               rresp_q, rresp_d;
    logic               aw_hs, ar_hs, aw_err, ar_err;
    logic [IDX_W-1:0]   w_idx, r_idx;
    logic [DATA_W-1:0]  ram_rdata;
    logic [DATA_W-1:0]  rdata_mux;

    assign aw_hs  = AWVALID & AWREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign aw_err = addr_err(AWADDR);
    assign ar_err = addr_err(ARADDR);
    assign w_idx  = IDX_W'(AWADDR >> OFF_W);
    assign r_idx  = IDX_W'(ARADDR >> OFF_W);

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (aw_hs & ~aw_err),
        .wstrb_i (WSTRB),
        .waddr_i (w_idx),
        .wdata_i (WDATA),
        .re_i    (ar_hs & ~ar_err),
        .raddr_i (r_idx),
        .rdata_o (ram_rdata)
    );

    // ---------------- write channel ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state_q <= W_IDLE;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    w_state_d = W_RESP;
                    bresp_d   = aw_err ? RESP_ERR : RESP_OKAY;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = (w_state_q == W_IDLE);
        BVALID  = (w_state_q == W_RESP);
    end

    assign BRESP = bresp_q;

    // ---------------- read channel ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q <= R_IDLE;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    r_state_d = R_DATA;
                    rresp_d   = ar_err ? RESP_ERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

`ifdef DMEM_FWD_EN
    // Capture the colliding write at read-accept time so the merge is stable while RREADY is low.
    logic               fwd_q, fwd_d;
    logic [STRB_W-1:0]  fwd_strb_q;
    logic [DATA_W-1:0]  fwd_data_q;

    assign fwd_d = aw_hs & ~aw_err & ~ar_err & (w_idx == r_idx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwd_q <= 1'b0;
        end else if (ar_hs) begin
            fwd_q <= fwd_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (ar_hs) begin
            fwd_strb_q <= WSTRB;
            fwd_data_q <= WDATA;
        end
    end

    always_comb begin
        rdata_mux = ram_rdata;
        for (int i = 0; i < STRB_W; i++) begin
            if (fwd_q && fwd_strb_q[i]) begin
                rdata_mux[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
    end
`else
    assign rdata_mux = ram_rdata;
`endif

    // RDATA is forced to zero outside a valid OK response: covers reset and error returns, and
    // the RAM output register only moves on a new accept, so data holds during a stall.
    always_comb begin
        ARREADY = (r_state_q == R_IDLE);
        RVALID  = (r_state_q == R_DATA);
        RDATA   = ((r_state_q == R_DATA) && (rresp_q == RESP_OKAY)) ? rdata_mux : '0;
    end

    assign RRESP = rresp_q;

endmodule
